// File: rtl/ysyx_22050710_mdu_if.sv
// Request/response channel between the execute stage and the multiply/divide unit.
// Latency: none, this is wiring only. Backpressure: o_ready gates requests, and i_ready holds a finished result.
// Ports: request i_valid/o_ready, i_op, i_word, i_src1, i_src2, i_flush; response o_valid/i_ready, o_result; status o_busy.
// Signal names follow the MDU's point of view: master = execute stage, slave = MDU.
interface ysyx_22050710_mdu_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic            i_word;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/ysyx_22050710_mdu.sv
// Iterative RV64M multiply/divide unit (MUL/MULH*/DIV*/REM* plus word forms).
// Latency: o_valid appears N edges after the accept edge (N=XLEN, or 32 in word mode); divide-by-zero and signed overflow are ready on the accept edge.
// Backpressure: accepts only in IDLE, holds o_valid/o_result until i_ready; i_flush aborts from any state.
// Ports: i_clk, i_rst_n (async, active-low), bus (slave modport of ysyx_22050710_mdu_if).
module ysyx_22050710_mdu #(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ysyx_22050710_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;      // mul: running product; div: remainder in the low half
  logic [2*XLEN-1:0] opa;      // mul: shifted multiplicand; div: dividend/quotient shift register
  logic [XLEN-1:0]   opb;      // mul: shifted multiplier; div: divisor magnitude
  logic              div_q, rem_q, hi_q, word_q, neg_q, valid_q;
  logic [XLEN-1:0]   result_q;

  // Sign-extend the low 32 bits when in word mode.
  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN-1:0] sx;
    sx       = {XLEN{v[31]}};
    sx[31:0] = v[31:0];
    return w ? sx : v;
  endfunction

  // Request decode, operand conditioning and fast-path detection.
  logic [2:0]      op;
  logic            op_mulh, op_udiv, wm, sgn1, sgn2, neg1, neg2, b_zero, ovf, fast;
  logic [XLEN-1:0] a_x, b_x, mag1, mag2, min_n, fast_res;

  always_comb begin
    op      = bus.i_op;
    op_mulh = ~op[2] & (op[1:0] != 2'b00);
    op_udiv = op[2] & op[0];
    wm      = WORD_EN & bus.i_word & ~op_mulh;
    sgn1    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    sgn2    = op[2] ? ~op[0] : ~op[1];
    a_x     = bus.i_src1;
    b_x     = bus.i_src2;
    if (wm) begin
      a_x       = {XLEN{bus.i_src1[31] & ~op_udiv}};
      a_x[31:0] = bus.i_src1[31:0];
      b_x       = {XLEN{bus.i_src2[31] & ~op_udiv}};
      b_x[31:0] = bus.i_src2[31:0];
    end
    neg1   = sgn1 & a_x[XLEN-1];
    neg2   = sgn2 & b_x[XLEN-1];
    mag1   = neg1 ? -a_x : a_x;
    mag2   = neg2 ? -b_x : b_x;
    // Most negative N-bit value, already sign-extended to XLEN.
    min_n  = wm ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
    b_zero = (b_x == '0);
    ovf    = op[2] & ~op[0] & (a_x == min_n) & (&b_x);
    fast   = op[2] & (b_zero | ovf);
    if (b_zero) fast_res = op[1] ? a_x : '1;
    else        fast_res = op[1] ? '0 : a_x;
    fast_res = fin(fast_res, wm);
  end

  // One iteration step plus the sign-corrected result of the final step.
  logic [XLEN:0]     part, diff;
  logic              ge;
  logic [2*XLEN-1:0] acc_nx, opa_nx, prod;
  logic [XLEN-1:0]   opb_nx, quo, rem, calc_res;

  always_comb begin
    part = {acc[XLEN-1:0], opa[XLEN-1]};
    diff = part - {1'b0, opb};
    // The remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
    ge   = ~diff[XLEN];
    if (div_q) begin
      acc_nx = {{XLEN{1'b0}}, ge ? diff[XLEN-1:0] : part[XLEN-1:0]};
      opa_nx = {{XLEN{1'b0}}, opa[XLEN-2:0], ge};
      opb_nx = opb;
    end else begin
      acc_nx = acc + (opb[0] ? opa : '0);
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -opa_nx[XLEN-1:0] : opa_nx[XLEN-1:0];
    rem  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    if (div_q) calc_res = fin(rem_q ? rem : quo, word_q);
    else       calc_res = hi_q ? prod[2*XLEN-1:XLEN] : fin(prod[XLEN-1:0], word_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      hi_q     <= 1'b0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (bus.i_flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            div_q  <= op[2];
            rem_q  <= op[1];
            hi_q   <= op_mulh;
            word_q <= wm;
            // Remainder follows the dividend's sign, everything else the product of signs.
            neg_q  <= (op[2] & op[1]) ? neg1 : (neg1 ^ neg2);
            acc    <= '0;
            opb    <= mag2;
            if (fast) begin
              result_q <= fast_res;
              valid_q  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
              cnt   <= wm ? CW'(32) : CW'(XLEN);
              // A word-mode dividend is left-aligned so its MSB enters the remainder first.
              opa   <= {{XLEN{1'b0}}, (op[2] & wm) ? (mag1 << (XLEN - 32)) : mag1};
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          opa <= opa_nx;
          opb <= opb_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_q <= calc_res;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_busy   = (state != IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// Bench for ysyx_22050710_mdu: directed vector table, random ops against an arithmetic reference model,
// and hand-written backpressure, flush and asynchronous-reset sequences.
// Ports: none; drives the DUT through a ysyx_22050710_mdu_if instance.
module tb_ysyx_22050710_mdu;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  ysyx_22050710_mdu_if #(.XLEN(64)) bus ();

  ysyx_22050710_mdu #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_word(input logic [2:0] op, input logic w);
    return w && !(op == MULH || op == MULHSU || op == MULHU);
  endfunction

  // Reference: native wide arithmetic plus the RISC-V divide corner rules.
  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic               wm;
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0]        r32;
    logic [63:0]        r;
    wm = is_word(op, w);
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
    r32 = '0; r = '0; p = '0;
    case (op)
      MUL: begin
        r = a * b;
        r32 = a[31:0] * b[31:0];
        if (wm) r = sx32(r32);
      end
      MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
      MULHU:  begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
      DIV: begin
        if (wm) begin
          if (wb == 0) r32 = '1;
          else if (wa == 32'sh8000_0000 && wb == -32'sd1) r32 = wa;
          else r32 = wa / wb;
          r = sx32(r32);
        end else begin
          if (sb == 0) r = '1;
          else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r = sa;
          else r = sa / sb;
        end
      end
      DIVU: begin
        if (wm) begin
          if (b[31:0] == 0) r32 = '1;
          else r32 = a[31:0] / b[31:0];
          r = sx32(r32);
        end else begin
          if (b == 0) r = '1;
          else r = a / b;
        end
      end
      REM: begin
        if (wm) begin
          if (wb == 0) r32 = wa;
          else if (wa == 32'sh8000_0000 && wb == -32'sd1) r32 = '0;
          else r32 = wa % wb;
          r = sx32(r32);
        end else begin
          if (sb == 0) r = sa;
          else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r = '0;
          else r = sa % sb;
        end
      end
      default: begin
        if (wm) begin
          if (b[31:0] == 0) r32 = a[31:0];
          else r32 = a[31:0] % b[31:0];
          r = sx32(r32);
        end else begin
          if (b == 0) r = a;
          else r = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Edges after the accept edge until o_valid: 0 for the divide corner cases, else N.
  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic wm;
    wm = is_word(op, w);
    if (op[2]) begin
      if (wm) begin
        if (b[31:0] == 0) return 0;
        if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 0;
      end else begin
        if (b == 0) return 0;
        if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 0;
      end
    end
    return wm ? 32 : 64;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return -64'($urandom_range(1, 20));
      3:       return 64'h8000_0000_0000_0000;
      4:       return {32'($urandom), 32'h8000_0000};
      default: return {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] res, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.w = w; v.a = a; v.b = b; v.res = res; v.lat = lat;
    tbl.push_back(v);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_word = w; bus.i_src1 = a; bus.i_src2 = b;
  endtask

  // Withdraw the request and garble the operand lines; the DUT must have registered them.
  task automatic scramble();
    bus.i_valid = 1'b0;
    bus.i_op    = 3'($urandom);
    bus.i_word  = 1'($urandom);
    bus.i_src1  = {$urandom, $urandom};
    bus.i_src2  = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.o_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    drive_req(op, w, a, b);
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input int lat_exp);
    int lat;
    issue(op, w, a, b);
    wait_valid(lat);
    check({name, " result"}, bus.o_result, res);
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    take();
  endtask

  initial begin
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b, held, exp;
    int          lat;
    logic        saw_valid;

    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_op = '0; bus.i_word = 1'b0;
    bus.i_src1 = '0; bus.i_src2 = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", 64'(bus.o_valid), 64'd0);
    check("reset o_ready", 64'(bus.o_ready), 64'd1);
    check("reset o_busy", 64'(bus.o_busy), 64'd0);
    check("reset o_result", bus.o_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add("mul_7xm3",     MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64);
    add("mulhu_ones",   MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    add("mulh_ones",    MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64);
    add("mulhsu_m1x2",  MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    add("div_by0",      DIV,    1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add("remu_by0",     REMU,   1'b0, 64'd5, 64'd0, 64'd5, 0);
    add("div_ovf",      DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
    add("rem_ovf",      REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    add("divw",         DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32);
    add("remw",         REM,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    add("divuw",        DIVU,   1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 32);
    add("mulw",         MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
    add("mulhu_word",   MULHU,  1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 64);
    add("remuw_by0",    REMU,   1'b1, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 0);
    add("divw_ovf",     DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    add("divu_full",    DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64);
    add("rem_neg",      REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);

    foreach (tbl[i]) run_one(tbl[i].name, tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      run_one($sformatf("rand%0d op%0d w%0d", i, op, w), op, w, a, b, ref_mdu(op, w, a, b), ref_lat(op, w, a, b));
    end

    // Backpressure: hold the result, then release while the next request waits.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    issue(MUL, 1'b0, a, b);
    wait_valid(lat);
    held = bus.o_result;
    check("bp first result", held, ref_mdu(MUL, 1'b0, a, b));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d o_valid", i), 64'(bus.o_valid), 64'd1);
      check($sformatf("bp hold%0d o_result", i), bus.o_result, held);
      check($sformatf("bp hold%0d o_ready", i), 64'(bus.o_ready), 64'd0);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    drive_req(REM, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'd10);
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check("bp handshake o_valid", 64'(bus.o_valid), 64'd0);
    check("bp handshake not accepted", 64'(bus.o_busy), 64'd0);
    @(posedge clk); #1;
    check("bp next accepted", 64'(bus.o_busy), 64'd1);
    scramble();
    wait_valid(lat);
    check("bp next result", bus.o_result, ref_mdu(REM, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'd10));
    check("bp next latency", 64'(lat), 64'd32);
    take();

    // Flush when the counter has reached 20, with a competing request on the same edge.
    issue(MUL, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321);
    saw_valid = 1'b0;
    repeat (44) begin
      @(posedge clk); #1;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    @(negedge clk);
    bus.i_flush = 1'b1;
    drive_req(DIVU, 1'b0, 64'd1000, 64'd7);
    @(posedge clk); #1;
    check("flush o_busy", 64'(bus.o_busy), 64'd0);
    check("flush o_valid", 64'(bus.o_valid), 64'd0);
    check("flush o_ready", 64'(bus.o_ready), 64'd1);
    check("flush no early valid", 64'(saw_valid), 64'd0);
    @(negedge clk);
    bus.i_flush = 1'b0;
    @(posedge clk); #1;
    check("post-flush accepted", 64'(bus.o_busy), 64'd1);
    scramble();
    wait_valid(lat);
    check("post-flush result", bus.o_result, 64'd142);
    check("post-flush latency", 64'(lat), 64'd64);
    take();

    // Asynchronous reset between edges in the middle of a divide.
    issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_0000, 64'd3);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst o_valid", 64'(bus.o_valid), 64'd0);
    check("async rst o_busy", 64'(bus.o_busy), 64'd0);
    check("async rst o_ready", 64'(bus.o_ready), 64'd1);
    check("async rst o_result", bus.o_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after reset remu", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 64);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
